// File: rtl/morph_row_sched.sv
// Row scheduler for the 19-row morphology core: sequences init/start/pixel/done per row and appends PAD flush rows per frame.
// Optional watchdog enabled by defining MORPH_ROW_SCHED_TIMEOUT_EN.
module morph_row_sched #(
  parameter int COLS    = 752,
  parameter int ROWS    = 480,
  parameter int PAD     = 9,
  parameter int TIMEOUT = 1023
) (
  input  logic       s_axi_aclk,
  input  logic       s_axi_aresetn,
  input  logic       sensor_state,
  input  logic       frame_start,
  input  logic       row_req,
  output logic       ap_start,
  input  logic       ap_ready,
  input  logic       ap_done,
  input  logic       ap_idle,
  output logic       core_init,
  output logic       pix_valid,
  output logic [9:0] col_cnt,
  output logic       flush_row,
  output logic [8:0] row_cnt,
  output logic       frame_done,
  output logic       overrun,
  output logic       err_timeout
);

  typedef enum logic [2:0] {IDLE, INIT, START, RUN, WAIT_DONE} state_t;

  localparam logic [9:0] COL_LAST  = 10'(COLS - 1);
  localparam logic [8:0] ROW_FLUSH = 9'(ROWS);
  localparam logic [8:0] ROW_LAST  = 9'(ROWS + PAD - 1);

  state_t state;
  logic   pending;
  logic   done_lat;
  logic   flush_phase;
  logic   req_ok;
  logic   start_req;
  logic   consume_pend;
  logic   wd_fire;

  // ap_idle is informational only; sequencing relies on ap_ready/ap_done.
  logic unused_ap_idle;
  assign unused_ap_idle = ap_idle;

  assign flush_phase  = (row_cnt >= ROW_FLUSH);
  assign req_ok       = row_req & sensor_state;
  // In IDLE a fresh request starts the row directly; a pending one is consumed instead.
  assign start_req    = (state == IDLE) && !flush_phase && !pending && req_ok;
  assign consume_pend = (state == IDLE) && !flush_phase && pending && sensor_state;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state      <= IDLE;
      pending    <= 1'b0;
      done_lat   <= 1'b0;
      ap_start   <= 1'b0;
      core_init  <= 1'b0;
      pix_valid  <= 1'b0;
      col_cnt    <= '0;
      flush_row  <= 1'b0;
      row_cnt    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else if (frame_start) begin
      state      <= IDLE;
      pending    <= 1'b0;
      done_lat   <= 1'b0;
      ap_start   <= 1'b0;
      core_init  <= 1'b0;
      pix_valid  <= 1'b0;
      col_cnt    <= '0;
      flush_row  <= 1'b0;
      row_cnt    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      core_init  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;

      if (consume_pend) begin
        pending <= req_ok;
      end else if (req_ok && !start_req) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_req || consume_pend || flush_phase) begin
            state     <= INIT;
            core_init <= 1'b1;
            flush_row <= flush_phase;
          end
        end
        INIT: begin
          state    <= START;
          ap_start <= 1'b1;
        end
        START: begin
          if (ap_ready) begin
            ap_start  <= 1'b0;
            pix_valid <= 1'b1;
            col_cnt   <= '0;
            done_lat  <= 1'b0;
            state     <= RUN;
          end else if (wd_fire) begin
            ap_start  <= 1'b0;
            flush_row <= 1'b0;
            state     <= IDLE;
          end
        end
        RUN: begin
          if (ap_done) done_lat <= 1'b1;
          if (col_cnt == COL_LAST) begin
            pix_valid <= 1'b0;
            col_cnt   <= '0;
            state     <= WAIT_DONE;
          end else begin
            col_cnt <= col_cnt + 10'd1;
          end
        end
        WAIT_DONE: begin
          if (ap_done || done_lat) begin
            done_lat  <= 1'b0;
            flush_row <= 1'b0;
            state     <= IDLE;
            if (row_cnt == ROW_LAST) begin
              row_cnt    <= '0;
              frame_done <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 9'd1;
            end
          end else if (wd_fire) begin
            flush_row <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MORPH_ROW_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  // Counts only while the core owes us a handshake; any other state restarts it.
  assign wd_active = ((state == START) && !ap_ready) ||
                     ((state == WAIT_DONE) && !ap_done && !done_lat);
  assign wd_fire   = wd_active && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (frame_start) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (wd_active && !wd_fire) wd_cnt <= wd_cnt + 1'b1;
      else                       wd_cnt <= '0;
      if (wd_fire) err_timeout <= 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_morph_row_sched.sv
// Self-checking bench for morph_row_sched with a reduced geometry and randomized core handshakes.
`timescale 1ns/1ps
module tb_morph_row_sched;
  localparam int COLS       = 12;
  localparam int ROWS       = 5;
  localparam int PAD        = 3;
  localparam int TIMEOUT    = 40;
  localparam int FRAME_ROWS = ROWS + PAD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor_state = 1'b1;
  logic       frame_start = 1'b0;
  logic       row_req = 1'b0;
  logic       ap_start;
  logic       ap_ready = 1'b0;
  logic       ap_done = 1'b0;
  logic       ap_idle = 1'b1;
  logic       core_init;
  logic       pix_valid;
  logic [9:0] col_cnt;
  logic       flush_row;
  logic [8:0] row_cnt;
  logic       frame_done;
  logic       overrun;
  logic       err_timeout;

  int checks = 0;
  int passes = 0;
  int exp_row = 0;
  bit exp_pend = 0;

  morph_row_sched #(.COLS(COLS), .ROWS(ROWS), .PAD(PAD), .TIMEOUT(TIMEOUT)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .sensor_state(sensor_state),
    .frame_start(frame_start), .row_req(row_req), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .core_init(core_init), .pix_valid(pix_valid), .col_cnt(col_cnt),
    .flush_row(flush_row), .row_cnt(row_cnt), .frame_done(frame_done),
    .overrun(overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Brings an idle, non-flush, no-pending scheduler into RUN and advances to column col.
  task automatic go_to_run(input int col);
    row_req = 1'b1;
    tick();
    row_req = 1'b0;
    tick();
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    repeat (col) tick();
  endtask

  // One full row; start source, flush flag, pending and row count come from the model.
  task automatic run_row(input int rdy_dly, input int done_dly, input int early_col, input int nreq);
    bit flush, need_req, last, req_now, ov_exp;
    flush    = (exp_row >= ROWS);
    need_req = !flush && !exp_pend;
    if (!flush && exp_pend) exp_pend = 0;
    if (need_req) row_req = 1'b1;
    tick();
    row_req = 1'b0;
    checks++; if (core_init !== 1'b1) $display("FAIL row_core_init: got %0d expected 1", core_init); else passes++;
    checks++; if (flush_row !== flush) $display("FAIL row_flush_init: got %0d expected %0d", flush_row, flush); else passes++;
    checks++; if (frame_done !== 1'b0) $display("FAIL frame_done_width: got %0d expected 0", frame_done); else passes++;
    tick();
    checks++; if ({ap_start, core_init} !== 2'b10) $display("FAIL row_ap_start: got %b expected 10", {ap_start, core_init}); else passes++;
    repeat (rdy_dly) begin
      tick();
      checks++; if ({ap_start, pix_valid} !== 2'b10) $display("FAIL start_hold: got %b expected 10", {ap_start, pix_valid}); else passes++;
    end
    ap_ready = 1'b1;
    for (int i = 0; i < COLS; i++) begin
      req_now = (nreq > 0) && (i == 2 || i == 4 || i == 6) && (i / 2 <= nreq);
      if (req_now) row_req = 1'b1;
      if (i == early_col) ap_done = 1'b1;
      tick();
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      row_req  = 1'b0;
      ov_exp   = req_now && exp_pend;
      if (req_now) exp_pend = 1;
      checks++; if ({pix_valid, col_cnt} !== {1'b1, 10'(i)}) $display("FAIL run_col: got %0d/%0d expected 1/%0d", pix_valid, col_cnt, i); else passes++;
      checks++; if (overrun !== ov_exp) $display("FAIL run_overrun: got %0d expected %0d at col %0d", overrun, ov_exp, i); else passes++;
      if (i == 0) begin
        checks++; if (ap_start !== 1'b0) $display("FAIL start_drop: got %0d expected 0", ap_start); else passes++;
      end
    end
    tick();
    checks++; if ({pix_valid, flush_row} !== {1'b0, flush}) $display("FAIL wait_entry: got %b expected %b", {pix_valid, flush_row}, {1'b0, flush}); else passes++;
    if (early_col >= 0) begin
      tick();
    end else begin
      repeat (done_dly) begin
        tick();
        checks++; if (row_cnt !== 9'(exp_row)) $display("FAIL wait_row_hold: got %0d expected %0d", row_cnt, exp_row); else passes++;
      end
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
    end
    last    = (exp_row == FRAME_ROWS - 1);
    exp_row = last ? 0 : exp_row + 1;
    checks++; if (row_cnt !== 9'(exp_row)) $display("FAIL row_cnt_step: got %0d expected %0d", row_cnt, exp_row); else passes++;
    checks++; if (frame_done !== last) $display("FAIL frame_done: got %0d expected %0d", frame_done, last); else passes++;
    checks++; if ({flush_row, pix_valid, ap_start} !== 3'b000) $display("FAIL row_exit: got %b expected 000", {flush_row, pix_valid, ap_start}); else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({ap_start, core_init, pix_valid, col_cnt, flush_row, row_cnt, frame_done, overrun, err_timeout} !== 26'd0)
      $display("FAIL reset_outputs: got %h expected 0", {ap_start, core_init, pix_valid, col_cnt, flush_row, row_cnt, frame_done, overrun, err_timeout}); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      checks++; if ({core_init, ap_start, row_cnt} !== 11'd0) $display("FAIL reset_idle: got %h expected 0", {core_init, ap_start, row_cnt}); else passes++;
    end
    exp_row = 0;
    exp_pend = 0;
  endtask

  task automatic test_sensor_off();
    sensor_state = 1'b0;
    row_req = 1'b1;
    tick();
    row_req = 1'b0;
    repeat (4) begin
      checks++; if ({core_init, overrun} !== 2'b00) $display("FAIL sensor_off_ignore: got %b expected 00", {core_init, overrun}); else passes++;
      tick();
    end
    sensor_state = 1'b1;
    repeat (3) begin
      tick();
      checks++; if (core_init !== 1'b0) $display("FAIL sensor_off_no_pending: got %0d expected 0", core_init); else passes++;
    end
  endtask

  task automatic test_nominal();
    run_row(2, 3, -1, 0);
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(0, 3)) begin
        tick();
        checks++; if (core_init !== 1'b0) $display("FAIL idle_quiet: got %0d expected 0", core_init); else passes++;
      end
      run_row($urandom_range(0, 4), $urandom_range(0, 5),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, COLS - 1)) : -1, 0);
    end
  endtask

  task automatic test_overrun();
    run_row($urandom_range(0, 3), $urandom_range(0, 3), -1, 3);
    run_row($urandom_range(0, 3), $urandom_range(0, 3), -1, 0);
  endtask

  task automatic test_frame_end();
    checks++; if (row_cnt !== 9'(ROWS)) $display("FAIL flush_entry_row: got %0d expected %0d", row_cnt, ROWS); else passes++;
    for (int p = 0; p < PAD; p++) begin
      sensor_state = (p == PAD - 1);
      run_row($urandom_range(0, 3), $urandom_range(0, 3), -1, (p == PAD - 1) ? 1 : 0);
    end
    sensor_state = 1'b1;
    run_row($urandom_range(0, 3), $urandom_range(0, 3), -1, 0);
  endtask

  task automatic test_frame_start();
    tick();
    go_to_run(5);
    checks++; if ({pix_valid, col_cnt} !== {1'b1, 10'd5}) $display("FAIL fs_setup: got %0d/%0d expected 1/5", pix_valid, col_cnt); else passes++;
    frame_start = 1'b1;
    row_req = 1'b1;
    tick();
    frame_start = 1'b0;
    row_req = 1'b0;
    exp_row = 0;
    exp_pend = 0;
    checks++; if ({pix_valid, ap_start, overrun, row_cnt} !== 12'd0) $display("FAIL fs_abort: got %h expected 0", {pix_valid, ap_start, overrun, row_cnt}); else passes++;
    repeat (4) begin
      tick();
      checks++; if ({core_init, pix_valid} !== 2'b00) $display("FAIL fs_req_lost: got %b expected 00", {core_init, pix_valid}); else passes++;
    end
  endtask

  task automatic test_reset_mid_run();
    run_row(1, 1, -1, 0);
    tick();
    go_to_run(2);
    row_req = 1'b1;
    tick();
    row_req = 1'b0;
    tick();
    checks++; if ({pix_valid, row_cnt} !== {1'b1, 9'd1}) $display("FAIL rst_setup: got %h expected %h", {pix_valid, row_cnt}, {1'b1, 9'd1}); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ap_start, core_init, pix_valid, col_cnt, flush_row, row_cnt, frame_done, overrun, err_timeout} !== 26'd0)
      $display("FAIL rst_async: got %h expected 0", {ap_start, core_init, pix_valid, col_cnt, flush_row, row_cnt, frame_done, overrun, err_timeout}); else passes++;
    #2 rst_n = 1'b1;
    exp_row = 0;
    exp_pend = 0;
    repeat (6) begin
      tick();
      checks++; if ({frame_done, overrun, core_init, row_cnt} !== 12'd0) $display("FAIL rst_release: got %h expected 0", {frame_done, overrun, core_init, row_cnt}); else passes++;
    end
  endtask

  task automatic test_timeout();
`ifdef MORPH_ROW_SCHED_TIMEOUT_EN
    run_row(1, 1, -1, 0);
    tick();
    go_to_run(COLS - 1);
    tick();
    checks++; if (pix_valid !== 1'b0) $display("FAIL to_wait_entry: got %0d expected 0", pix_valid); else passes++;
    repeat (TIMEOUT - 1) begin
      tick();
      checks++; if (err_timeout !== 1'b0) $display("FAIL to_early: got %0d expected 0", err_timeout); else passes++;
    end
    tick();
    checks++; if ({err_timeout, row_cnt} !== {1'b1, 9'(exp_row)}) $display("FAIL to_fire: got %h expected %h", {err_timeout, row_cnt}, {1'b1, 9'(exp_row)}); else passes++;
    tick();
    checks++; if ({err_timeout, core_init, ap_start} !== 3'b100) $display("FAIL to_sticky: got %b expected 100", {err_timeout, core_init, ap_start}); else passes++;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_row = 0;
    checks++; if (err_timeout !== 1'b0) $display("FAIL to_clear: got %0d expected 0", err_timeout); else passes++;
`else
    run_row(TIMEOUT + 5, TIMEOUT + 5, -1, 0);
    checks++; if (err_timeout !== 1'b0) $display("FAIL no_watchdog: got %0d expected 0", err_timeout); else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_sensor_off();
    test_nominal();
    test_overrun();
    test_frame_end();
    test_frame_start();
    test_reset_mid_run();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/morph_row_sched.md
MORPH_ROW_SCHED -- requirements
Module: morph_row_sched

Interface
REQ-001 Parameters SHALL be, one per line:
  COLS, 752, pixels per row streamed to the morphology core.
  ROWS, 480, input rows per frame.
  PAD, 9, flush rows appended after the last input row (half of the 19-row window).
  TIMEOUT, 1023, watchdog limit in cycles.
REQ-002 Ports SHALL be, one per line:
  s_axi_aclk  in  1  sole clock; all logic on the rising edge.
  s_axi_aresetn  in  1  asynchronous, active-low reset.
  sensor_state  in  1  1 = accept new rows.
  frame_start  in  1  one-cycle pulse; synchronous frame restart.
  row_req  in  1  one-cycle pulse; line buffer holds a complete window for the next row.
  ap_start  out  1  HLS core start.
  ap_ready  in  1  core accepted the start.
  ap_done  in  1  core finished the row.
  ap_idle  in  1  core idle; status only.
  core_init  out  1  one-cycle pulse before each row start.
  pix_valid  out  1  pixel-stream window, COLS cycles per row.
  col_cnt  out  10  pixel index while pix_valid=1.
  flush_row  out  1  current row is a pad row; datapath injects 8'd255.
  row_cnt  out  9  index of the current row, 0..ROWS+PAD-1.
  frame_done  out  1  one-cycle pulse after the last pad row completes.
  overrun  out  1  one-cycle pulse when a row_req is dropped.
  err_timeout  out  1  sticky watchdog error.

Function
REQ-003 The FSM SHALL have states IDLE, INIT, START, RUN and WAIT_DONE.
REQ-004 IDLE->INIT SHALL occur on (row_req or pending) with sensor_state=1, or on the auto flush condition (REQ-010).
REQ-005 INIT SHALL last exactly 1 cycle with core_init=1, then go to START.
REQ-006 START SHALL hold ap_start=1 until ap_ready=1 is sampled; ap_start SHALL drop the following cycle, and the FSM SHALL then enter RUN.
REQ-007 RUN SHALL assert pix_valid for exactly COLS consecutive cycles, with col_cnt counting 0..COLS-1, then enter WAIT_DONE.
REQ-008 WAIT_DONE SHALL exit on ap_done=1: row_cnt increments, and the FSM returns to IDLE.
  - ap_done seen during RUN SHALL be latched and honoured on entry to WAIT_DONE.
REQ-009 A row_req accepted outside IDLE SHALL set a one-deep pending flag.
  - row_req while pending is already set SHALL be dropped, with overrun=1 for 1 cycle.
  - row_req when sensor_state=0 SHALL be ignored without overrun.
REQ-010 Once row_cnt reaches ROWS, the scheduler SHALL issue PAD rows without row_req, with flush_row=1 from INIT through WAIT_DONE.
  - Flush rows SHALL proceed regardless of sensor_state.
  - row_req during flush SHALL be pending/overrun per REQ-009.
REQ-011 On completion of row ROWS+PAD-1, frame_done SHALL pulse 1 cycle, row_cnt SHALL wrap to 0, and pending SHALL be retained.
REQ-012 frame_start SHALL have priority over all other events: FSM to IDLE, row_cnt=0, pending=0, ap_start=0, pix_valid=0, err_timeout cleared.
  - A simultaneous row_req SHALL be lost, without overrun.
REQ-013 sensor_state falling mid-row SHALL NOT abort the row.
REQ-014 Latency SHALL be 2 cycles from row_req in IDLE to ap_start=1, and 1 cycle from ap_ready to the first pix_valid.

Reset
REQ-015 Asserting s_axi_aresetn low SHALL immediately force the FSM to IDLE and clear all counters, the pending flag and all outputs (all outputs 0).
REQ-016 Reset asserted mid-row SHALL abandon the row; no frame_done or overrun SHALL be generated on release.

Configuration
REQ-017 With MORPH_ROW_SCHED_TIMEOUT_EN defined, the watchdog SHALL be active:
  - A counter runs in START and WAIT_DONE.
  - After TIMEOUT cycles without ap_ready or ap_done: err_timeout=1 (sticky until frame_start or reset), ap_start=0, FSM to IDLE, row discarded, row_cnt unchanged.
REQ-018 Without MORPH_ROW_SCHED_TIMEOUT_EN, no watchdog logic SHALL exist, err_timeout SHALL be tied 0, and START/WAIT_DONE SHALL wait indefinitely.

Verification
REQ-019 Nominal row: row_req at t0, ap_ready at t0+4 -> ap_start high t0+2..t0+4, pix_valid for 752 cycles, row_cnt 0->1 on ap_done.
REQ-020 Frame end: 480 row_req -> 9 auto rows with flush_row=1, then frame_done pulse, row_cnt=0.
REQ-021 Overflow: three row_req during one RUN -> first sets pending, second sets overrun=1, next row starts automatically 2 cycles after IDLE.
REQ-022 frame_start asserted during RUN at col_cnt=300 -> next cycle pix_valid=0, row_cnt=0, IDLE.
REQ-023 With MORPH_ROW_SCHED_TIMEOUT_EN defined, ap_done withheld -> err_timeout=1 after 1023 WAIT_DONE cycles; cleared by frame_start.
REQ-024 Reset pulsed mid-RUN -> all outputs 0 asynchronously; no frame_done after release.
